// File: rtl/mem_stage.sv
// Memory access stage: byte/half/word loads and stores on a word-organised
// data memory, with a post-reset clear sequence and a debug read port.
module mem_stage #(
  parameter int DATA_SIZE     = 32,
  parameter int MEM_ADDR_SIZE = 8,
  parameter int REG_ADDR_SIZE = 5
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_enable,
  input  logic                     i_mem_rd,
  input  logic                     i_mem_wr,
  input  logic [1:0]               i_mem_size,
  input  logic                     i_unsigned,
  input  logic [DATA_SIZE-1:0]     i_alu_result,
  input  logic [DATA_SIZE-1:0]     i_data_wr,
  input  logic                     i_wb,
  input  logic                     i_mem_to_reg,
  input  logic                     i_halt,
  input  logic [REG_ADDR_SIZE-1:0] i_addr_wr,
  input  logic [MEM_ADDR_SIZE-1:0] i_dbg_addr,
  output logic [DATA_SIZE-1:0]     o_mem_result,
  output logic [DATA_SIZE-1:0]     o_alu_result,
  output logic                     o_wb,
  output logic                     o_mem_to_reg,
  output logic                     o_halt,
  output logic [REG_ADDR_SIZE-1:0] o_addr_wr,
  output logic [DATA_SIZE-1:0]     o_dbg_data,
  output logic                     o_misaligned,
  output logic                     o_busy
);

  localparam int DEPTH = 1 << MEM_ADDR_SIZE;
  localparam logic [MEM_ADDR_SIZE-1:0] LAST = MEM_ADDR_SIZE'(DEPTH - 1);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t                   r_state;
  state_t                   w_next;
  logic [MEM_ADDR_SIZE-1:0] r_cnt;
  logic [31:0]              r_mem [DEPTH];

  logic [MEM_ADDR_SIZE-1:0] w_idx;
  logic [1:0]               w_off;
  logic                     w_is_byte;
  logic                     w_is_half;
  logic                     w_is_word;
  logic                     w_store;
  logic                     w_clr_we;
  logic [3:0]               w_be;
  logic [31:0]              w_wdata;
  logic [31:0]              w_rword;
  logic [7:0]               w_byte;
  logic [15:0]              w_half;

  assign o_alu_result = i_alu_result;
  assign o_wb         = i_wb;
  assign o_mem_to_reg = i_mem_to_reg;
  assign o_halt       = i_halt;
  assign o_addr_wr    = i_addr_wr;

  // Upper address bits are ignored, so addresses wrap around the memory.
  assign w_idx     = i_alu_result[MEM_ADDR_SIZE+1:2];
  assign w_off     = i_alu_result[1:0];
  assign w_is_byte = (i_mem_size == 2'b00);
  assign w_is_half = (i_mem_size == 2'b01);
  assign w_is_word = i_mem_size[1];

  assign o_misaligned = (i_mem_rd | i_mem_wr) &
    ((w_is_half & w_off[0]) | (w_is_word & (|w_off)));

  assign w_store = i_enable & i_mem_wr & ~o_busy &
                   ~o_misaligned & ~i_reset;

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = i_data_wr[31:0];
    unique case (1'b1)
      w_is_byte: begin
        w_be    = 4'b0001 << w_off;
        w_wdata = {4{i_data_wr[7:0]}};
      end
      w_is_half: begin
        w_be    = w_off[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{i_data_wr[15:0]}};
      end
      w_is_word: begin
        w_be    = 4'b1111;
        w_wdata = i_data_wr[31:0];
      end
    endcase
  end

  assign w_rword = r_mem[w_idx];
  assign w_byte  = w_rword[8*w_off +: 8];
  assign w_half  = w_off[1] ? w_rword[31:16] : w_rword[15:0];

  always_comb begin
    o_mem_result = '0;
    if (i_mem_rd & ~o_misaligned & ~o_busy) begin
      unique case (1'b1)
        w_is_byte: o_mem_result =
          {{(DATA_SIZE-8){w_byte[7] & ~i_unsigned}}, w_byte};
        w_is_half: o_mem_result =
          {{(DATA_SIZE-16){w_half[15] & ~i_unsigned}}, w_half};
        w_is_word: o_mem_result = DATA_SIZE'(w_rword);
      endcase
    end
  end

  assign o_dbg_data = DATA_SIZE'(r_mem[i_dbg_addr]);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_CLEAR)
        r_cnt <= r_cnt + MEM_ADDR_SIZE'(1);
    end
  end

  always_comb begin
    w_next = r_state;
    if (r_state == S_CLEAR && r_cnt == LAST)
      w_next = S_IDLE;
  end

  always_comb begin
    o_busy   = (r_state == S_CLEAR);
    w_clr_we = (r_state == S_CLEAR) & ~i_reset;
  end

  // Clear and store never overlap: stores are blocked while busy.
  always_ff @(posedge i_clk) begin
    if (w_clr_we) begin
      r_mem[r_cnt] <= '0;
    end else if (w_store) begin
      for (int k = 0; k < 4; k++)
        if (w_be[k])
          r_mem[w_idx][8*k +: 8] <= w_wdata[8*k +: 8];
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: vector table for load/store behaviour,
// hand sequences for clear timing, reset restart and debug-port ordering.
module tb_mem_stage;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_enable;
  logic        i_mem_rd;
  logic        i_mem_wr;
  logic [1:0]  i_mem_size;
  logic        i_unsigned;
  logic [31:0] i_alu_result;
  logic [31:0] i_data_wr;
  logic        i_wb;
  logic        i_mem_to_reg;
  logic        i_halt;
  logic [4:0]  i_addr_wr;
  logic [7:0]  i_dbg_addr;
  logic [31:0] o_mem_result;
  logic [31:0] o_alu_result;
  logic        o_wb;
  logic        o_mem_to_reg;
  logic        o_halt;
  logic [4:0]  o_addr_wr;
  logic [31:0] o_dbg_data;
  logic        o_misaligned;
  logic        o_busy;

  int g_tests = 0;
  int g_fails = 0;

  mem_stage dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable),
    .i_mem_rd(i_mem_rd), .i_mem_wr(i_mem_wr),
    .i_mem_size(i_mem_size), .i_unsigned(i_unsigned),
    .i_alu_result(i_alu_result), .i_data_wr(i_data_wr),
    .i_wb(i_wb), .i_mem_to_reg(i_mem_to_reg), .i_halt(i_halt),
    .i_addr_wr(i_addr_wr), .i_dbg_addr(i_dbg_addr),
    .o_mem_result(o_mem_result), .o_alu_result(o_alu_result),
    .o_wb(o_wb), .o_mem_to_reg(o_mem_to_reg), .o_halt(o_halt),
    .o_addr_wr(o_addr_wr), .o_dbg_data(o_dbg_data),
    .o_misaligned(o_misaligned), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  sz;
    logic        uns;
    logic        en;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_res;
    logic        exp_mis;
  } vec_t;

  vec_t v[25];

  function automatic vec_t mk(logic rd, logic wr, logic [1:0] sz,
                              logic uns, logic en, logic [31:0] addr,
                              logic [31:0] wd, logic [31:0] er,
                              logic em);
    vec_t t;
    t.rd = rd; t.wr = wr; t.sz = sz; t.uns = uns; t.en = en;
    t.addr = addr; t.wd = wd; t.exp_res = er; t.exp_mis = em;
    return t;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    g_tests++;
    if (act !== exp) begin
      g_fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    i_mem_rd = 0; i_mem_wr = 0; i_enable = 1;
    i_mem_size = 2'b11; i_unsigned = 0;
    i_alu_result = 0; i_data_wr = 0;
  endtask

  task automatic count_busy(string name, bit hold_store);
    int n = 0;
    while (o_busy && n < 400) begin
      @(negedge i_clk);
      n++;
      if (n == 50 && hold_store) begin
        #2;
        chk({name, "_rd_busy"}, o_mem_result, 32'h0);
      end
    end
    chk(name, n, 256);
  endtask

  initial begin
    idle();
    i_reset = 1; i_wb = 0; i_mem_to_reg = 0; i_halt = 0;
    i_addr_wr = 0; i_dbg_addr = 0;
    repeat (3) @(negedge i_clk);
    i_mem_rd = 1;
    #2;
    chk("reset_busy", {31'b0, o_busy}, 32'h1);
    chk("reset_result", o_mem_result, 32'h0);
    i_mem_rd = 0;
    @(negedge i_clk);
    i_reset = 0;
    #1;
    count_busy("clear_len", 0);
    i_dbg_addr = 0;   #1; chk("dbg0",   o_dbg_data, 0);
    i_dbg_addr = 127; #1; chk("dbg127", o_dbg_data, 0);
    i_dbg_addr = 255; #1; chk("dbg255", o_dbg_data, 0);

    v[0]  = mk(0,1,2'b11,0,1,32'h10, 32'hDEADBEEF,32'h0,       0);
    v[1]  = mk(1,0,2'b00,0,1,32'h11, 32'h0,       32'hFFFFFFBE,0);
    v[2]  = mk(1,0,2'b01,1,1,32'h12, 32'h0,       32'h0000DEAD,0);
    v[3]  = mk(1,0,2'b01,0,1,32'h12, 32'h0,       32'hFFFFDEAD,0);
    v[4]  = mk(1,0,2'b00,1,1,32'h11, 32'h0,       32'h000000BE,0);
    v[5]  = mk(0,1,2'b00,0,1,32'h13, 32'h1234565A,32'h0,       0);
    v[6]  = mk(1,0,2'b11,1,1,32'h10, 32'h0,       32'h5AADBEEF,0);
    v[7]  = mk(1,0,2'b11,0,1,32'h10, 32'h0,       32'h5AADBEEF,0);
    v[8]  = mk(0,1,2'b11,0,1,32'h22, 32'h11223344,32'h0,       1);
    v[9]  = mk(1,0,2'b11,0,1,32'h22, 32'h0,       32'h0,       1);
    v[10] = mk(1,0,2'b11,0,1,32'h20, 32'h0,       32'h0,       0);
    v[11] = mk(0,1,2'b11,0,0,32'h24, 32'hAABBCCDD,32'h0,       0);
    v[12] = mk(1,0,2'b11,0,1,32'h24, 32'h0,       32'h0,       0);
    v[13] = mk(1,0,2'b11,0,1,32'h400,32'h0,       32'h0,       0);
    v[14] = mk(0,1,2'b11,0,1,32'h400,32'hCAFEF00D,32'h0,       0);
    v[15] = mk(1,0,2'b11,0,1,32'h0,  32'h0,       32'hCAFEF00D,0);
    v[16] = mk(0,1,2'b01,0,1,32'h16, 32'hFFFF8001,32'h0,       0);
    v[17] = mk(1,0,2'b11,0,1,32'h14, 32'h0,       32'h80010000,0);
    v[18] = mk(1,1,2'b11,0,1,32'h14, 32'h01020304,32'h80010000,0);
    v[19] = mk(1,0,2'b11,0,1,32'h14, 32'h0,       32'h01020304,0);
    v[20] = mk(1,0,2'b01,0,1,32'h15, 32'h0,       32'h0,       1);
    v[21] = mk(1,0,2'b10,0,1,32'h14, 32'h0,       32'h01020304,0);
    v[22] = mk(1,0,2'b00,0,1,32'h17, 32'h0,       32'h00000001,0);
    v[23] = mk(0,0,2'b11,0,1,32'h23, 32'h0,       32'h0,       0);
    v[24] = mk(1,0,2'b00,0,1,32'h402,32'h0,       32'hFFFFFFFE,0);

    for (int i = 0; i < 25; i++) begin
      @(negedge i_clk);
      i_mem_rd = v[i].rd; i_mem_wr = v[i].wr;
      i_mem_size = v[i].sz; i_unsigned = v[i].uns;
      i_enable = v[i].en; i_alu_result = v[i].addr;
      i_data_wr = v[i].wd;
      i_wb = i[0]; i_mem_to_reg = i[1]; i_halt = i[2];
      i_addr_wr = 5'(i) ^ 5'h15;
      #2;
      chk($sformatf("v%0d_res", i), o_mem_result, v[i].exp_res);
      chk($sformatf("v%0d_mis", i), {31'b0, o_misaligned},
          {31'b0, v[i].exp_mis});
      chk($sformatf("v%0d_pass", i),
          {24'b0, o_wb, o_mem_to_reg, o_halt, o_addr_wr},
          {24'b0, i[0], i[1], i[2], 5'(i) ^ 5'h15});
      chk($sformatf("v%0d_alu", i), o_alu_result, v[i].addr);
    end

    @(negedge i_clk);
    idle();
    i_dbg_addr = 8'd9;
    i_mem_wr = 1; i_alu_result = 32'h24; i_data_wr = 32'h55667788;
    #2;
    chk("dbg_pre_edge", o_dbg_data, 32'h0);
    @(negedge i_clk);
    i_mem_wr = 0;
    #2;
    chk("dbg_post_edge", o_dbg_data, 32'h55667788);
    i_dbg_addr = 8'd4; #1;
    chk("dbg_word4", o_dbg_data, 32'h5AADBEEF);

    @(negedge i_clk);
    i_reset = 1;
    @(negedge i_clk);
    i_reset = 0;
    repeat (100) @(negedge i_clk);
    chk("mid_clear_busy", {31'b0, o_busy}, 32'h1);
    i_reset = 1;
    @(negedge i_clk);
    i_reset = 0;
    i_mem_rd = 1; i_mem_wr = 1; i_enable = 1;
    i_mem_size = 2'b11; i_alu_result = 32'h0; i_data_wr = 32'h77;
    #1;
    count_busy("restart_len", 1);
    idle();
    i_dbg_addr = 0; #1;
    chk("busy_store_blocked", o_dbg_data, 32'h0);
    i_dbg_addr = 9; #1;
    chk("cleared_word9", o_dbg_data, 32'h0);

    $display("[TB] %0d tests run, %0d failed", g_tests, g_fails);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter DATA_SIZE, default 32, data and address bus width.
REQ-002 Parameter MEM_ADDR_SIZE, default 8, log2 of data-memory depth in 32-bit words (DEPTH = 2^MEM_ADDR_SIZE).
REQ-003 Parameter REG_ADDR_SIZE, default 5, register-file write-address width.
REQ-004 i_clk  in  1  clock; all state changes on rising edge.
REQ-005 i_reset  in  1  reset, synchronous, active-high.
REQ-006 i_enable  in  1  pipeline step enable; stores commit only when high.
REQ-007 i_mem_rd / i_mem_wr  in  1 each  load / store request.
REQ-008 i_mem_size  in  2  access size: 00 byte, 01 halfword, 11 word, 10 treated as word.
REQ-009 i_unsigned  in  1  load extension: 1 zero-extend, 0 sign-extend.
REQ-010 i_alu_result  in  DATA_SIZE  effective byte address, also passed through.
REQ-011 i_data_wr  in  DATA_SIZE  store data; byte/half taken from low bits.
REQ-012 i_wb, i_mem_to_reg, i_halt  in  1 each  control, passed through.
REQ-013 i_addr_wr  in  REG_ADDR_SIZE  destination register, passed through.
REQ-014 i_dbg_addr  in  MEM_ADDR_SIZE  debug word index.
REQ-015 o_mem_result  out  DATA_SIZE  extended load data, combinational.
REQ-016 o_alu_result, o_wb, o_mem_to_reg, o_halt, o_addr_wr  out  same widths as inputs  combinational pass-through.
REQ-017 o_dbg_data  out  DATA_SIZE  word at i_dbg_addr, combinational.
REQ-018 o_misaligned  out  1  current load/store is misaligned, combinational.
REQ-019 o_busy  out  1  memory-clear sequence in progress, registered.

Function
REQ-020 Memory: DEPTH x 32-bit words, little-endian, word index = i_alu_result[MEM_ADDR_SIZE+1:2]; upper address bits ignored (wrap-around).
REQ-021 Read is asynchronous; byte lane = addr[1:0], half lane = addr[1].
REQ-022 Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=00; o_misaligned = (i_mem_rd|i_mem_wr) & misaligned.
REQ-023 Store commits at rising edge iff i_enable & i_mem_wr & !o_busy & !o_misaligned; only addressed lanes written (byte 1 lane, half 2 lanes, word 4).
REQ-024 o_mem_result = 0 when !i_mem_rd, misaligned, or o_busy; else selected lane sign/zero-extended per i_unsigned; word loads unaffected by i_unsigned.
REQ-025 Pass-through outputs are unaffected by i_enable, o_busy and misalignment.
REQ-026 FSM states IDLE, CLEAR; 0..DEPTH-1 word counter.
REQ-027 i_reset high: next state CLEAR, counter 0, o_busy 1, no memory write that cycle.
REQ-028 CLEAR with i_reset low: each edge writes 0 at counter, counter+1; edge writing DEPTH-1 moves to IDLE, o_busy 0 after that edge.
REQ-029 o_busy therefore stays high exactly DEPTH cycles after i_reset falls; clear proceeds regardless of i_enable.
REQ-030 Reset during CLEAR restarts at counter 0.
REQ-031 Store and debug read same word same cycle: o_dbg_data shows pre-edge value; new value visible next cycle.
REQ-032 Simultaneous i_mem_rd and i_mem_wr: store commits, o_mem_result shows pre-edge data.

Reset
REQ-033 After reset: state CLEAR, counter 0, o_busy 1, o_mem_result 0; after clear all memory words and o_dbg_data read 0.

Verification
REQ-034 Reset 1 cycle, DEPTH=256 -> o_busy high 256 cycles then low; o_dbg_data=0 for indices 0, 127, 255.
REQ-035 Store word 0xDEADBEEF at 0x10, next cycle load byte signed at 0x11 -> 0xFFFFFFBE; unsigned half at 0x12 -> 0x0000DEAD.
REQ-036 Store byte 0x5A at 0x13 over 0xDEADBEEF -> word at 0x10 reads 0x5AADBEEF.
REQ-037 Store word at 0x22 -> o_misaligned 1, memory unchanged, load word at 0x22 returns 0.
REQ-038 Store with i_enable 0, or during o_busy -> memory unchanged; reset asserted at clear counter 100 -> o_busy lasts full 256 cycles from new deassertion.
REQ-039 Address 0x400 with MEM_ADDR_SIZE 8 -> aliases word 0; pass-through outputs track inputs in every scenario.
